// File: rtl/lbm_pkg.sv
// Shared types and defaults for the LBM per-field grid stores.
// Defaults: 16x16 lattice, IEEE-754 single words, 1.0f init word.
package lbm_pkg;

    localparam int LBM_GRID_DIM   = 256;
    localparam int LBM_DATA_WIDTH = 32;
    localparam int LBM_ADDR_WIDTH = $clog2(LBM_GRID_DIM);

    localparam logic [31:0] LBM_ONE = 32'h3F80_0000;

    typedef logic [LBM_ADDR_WIDTH-1:0] node_idx_t;
    typedef logic [LBM_DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/lbm_field_store_if.sv
// Controller <-> field store strobe bus.
// master: controller side (drives strobes/addresses), slave: field store.
//  count_init_en, WE, select, wr_addr, wr_data, rd_en, rd_addr : master -> slave
//  count_init, init_done, rd_data, rd_valid                   : slave -> master
interface lbm_field_store_if
    import lbm_pkg::*;
#(
    parameter int ADDR_WIDTH = LBM_ADDR_WIDTH,
    parameter int DATA_WIDTH = LBM_DATA_WIDTH
);

    logic                  count_init_en;
    logic [ADDR_WIDTH-1:0] count_init;
    logic                  init_done;
    logic                  WE;
    logic                  select;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;

    modport master (
        output count_init_en,
        output WE,
        output select,
        output wr_addr,
        output wr_data,
        output rd_en,
        output rd_addr,
        input  count_init,
        input  init_done,
        input  rd_data,
        input  rd_valid
    );

    modport slave (
        input  count_init_en,
        input  WE,
        input  select,
        input  wr_addr,
        input  wr_data,
        input  rd_en,
        input  rd_addr,
        output count_init,
        output init_done,
        output rd_data,
        output rd_valid
    );

endinterface

// File: rtl/lbm_init_counter.sv
// Grid-initialisation node index with wrap at GRID_DIM-1.
// Ports: clk, rst (async high), en (advance), count (index), done (count==GRID_DIM-1).
module lbm_init_counter
    import lbm_pkg::*;
#(
    parameter int GRID_DIM   = LBM_GRID_DIM,
    parameter int ADDR_WIDTH = $clog2(GRID_DIM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] count,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(GRID_DIM - 1);

    logic [ADDR_WIDTH-1:0] count_nxt;

    always_comb begin
        count_nxt = count;
        if (en) begin
            count_nxt = (count == LAST) ? '0 : count + 1'b1;
        end
    end

    // done is registered off the next count so it tracks count exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            done  <= 1'b0;
        end else begin
            count <= count_nxt;
            done  <= (count_nxt == LAST);
        end
    end

endmodule

// File: rtl/lbm_field_store.sv
// Per-field lattice memory (p, ux, uy, fin, fout, feq) behind the strobe bus.
// Ports: Clk, Reset (async high), bus (slave side of lbm_field_store_if).
module lbm_field_store
    import lbm_pkg::*;
#(
    parameter int                    GRID_DIM   = LBM_GRID_DIM,
    parameter int                    DATA_WIDTH = LBM_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = $clog2(GRID_DIM),
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = DATA_WIDTH'(LBM_ONE)
) (
    input  logic              Clk,
    input  logic              Reset,
    lbm_field_store_if.slave  bus
);

    localparam logic [ADDR_WIDTH:0] NODES = (ADDR_WIDTH + 1)'(GRID_DIM);

    logic [DATA_WIDTH-1:0] mem [GRID_DIM];

    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [DATA_WIDTH-1:0] wr_word;
    logic                  wr_ok;
    logic                  rd_ok;

    lbm_init_counter #(
        .GRID_DIM   (GRID_DIM),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init_counter (
        .clk   (Clk),
        .rst   (Reset),
        .en    (bus.count_init_en),
        .count (bus.count_init),
        .done  (bus.init_done)
    );

    // Init writes use the pre-increment index so a held sweep covers every node
    always_comb begin
        wr_idx  = bus.wr_addr;
        wr_word = bus.wr_data;
        if (bus.select) begin
            wr_idx  = bus.count_init;
            wr_word = INIT_VALUE;
        end
    end

    // Only matters when GRID_DIM is not a power of two
    assign wr_ok = ({1'b0, wr_idx} < NODES);
    assign rd_ok = ({1'b0, bus.rd_addr} < NODES);

    always_ff @(posedge Clk) begin
        if (bus.WE && wr_ok) begin
            mem[wr_idx] <= wr_word;
        end
    end

    // Same-address read during write sees the old word
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
        end else begin
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                bus.rd_data <= rd_ok ? mem[bus.rd_addr] : '0;
            end
        end
    end

endmodule

// File: tb/tb_lbm_field_store.sv
// Directed bench for lbm_field_store: reset, init sweep, datapath
// writes, read-during-write, WE=0 hold and reset mid-sweep.
module tb_lbm_field_store;
    import lbm_pkg::*;

    logic Clk;
    logic Reset;

    int total = 0;
    int bad   = 0;

    lbm_field_store_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    lbm_field_store dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic rd(input string tag,
                      input logic [7:0] addr,
                      input logic [31:0] exp);
        bus.rd_en   = 1'b1;
        bus.rd_addr = addr;
        step();
        check({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
        check({tag, "_data"}, bus.rd_data, exp);
    endtask

    initial begin
        Reset             = 1'b0;
        bus.count_init_en = 1'b0;
        bus.WE            = 1'b0;
        bus.select        = 1'b0;
        bus.wr_addr       = '0;
        bus.wr_data       = '0;
        bus.rd_en         = 1'b0;
        bus.rd_addr       = '0;

        // 1: async reset, no clock edge yet
        #2;
        Reset = 1'b1;
        #1;
        check("rst_count", 32'(bus.count_init), 32'd0);
        check("rst_done", 32'(bus.init_done), 32'd0);
        check("rst_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_data", bus.rd_data, 32'd0);
        step();
        step();
        Reset = 1'b0;

        // 2: init sweep
        bus.WE            = 1'b1;
        bus.select        = 1'b1;
        bus.count_init_en = 1'b1;
        for (int i = 0; i < 254; i++) step();
        check("sweep254_count", 32'(bus.count_init), 32'd254);
        check("sweep254_done", 32'(bus.init_done), 32'd0);
        step();
        check("sweep255_count", 32'(bus.count_init), 32'd255);
        check("sweep255_done", 32'(bus.init_done), 32'd1);
        step();
        check("sweep256_count", 32'(bus.count_init), 32'd0);
        check("sweep256_done", 32'(bus.init_done), 32'd0);
        bus.WE            = 1'b0;
        bus.select        = 1'b0;
        bus.count_init_en = 1'b0;
        rd("init_n0", 8'd0, 32'h3F80_0000);
        rd("init_n17", 8'd17, 32'h3F80_0000);
        rd("init_n255", 8'd255, 32'h3F80_0000);
        bus.rd_en = 1'b0;

        // 3: datapath write then read
        bus.WE      = 1'b1;
        bus.select  = 1'b0;
        bus.wr_addr = 8'h2A;
        bus.wr_data = 32'hDEAD_BEEF;
        step();
        bus.WE = 1'b0;
        rd("dp_2a", 8'h2A, 32'hDEAD_BEEF);
        bus.rd_en = 1'b0;
        step();
        check("idle_valid", 32'(bus.rd_valid), 32'd0);
        check("idle_hold", bus.rd_data, 32'hDEAD_BEEF);

        // 4: read-during-write at node 5
        bus.WE      = 1'b1;
        bus.wr_addr = 8'h05;
        bus.wr_data = 32'h1234_5678;
        rd("rdw_old", 8'h05, 32'h3F80_0000);
        bus.WE = 1'b0;
        rd("rdw_new", 8'h05, 32'h1234_5678);
        bus.rd_en = 1'b0;

        // 5: WE=0 with select toggling, counter still advances
        bus.WE            = 1'b0;
        bus.count_init_en = 1'b1;
        bus.wr_addr       = 8'h10;
        bus.wr_data       = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            bus.select = (i % 2 == 0);
            step();
        end
        bus.count_init_en = 1'b0;
        bus.select        = 1'b0;
        check("we0_count", 32'(bus.count_init), 32'd3);
        rd("we0_n10", 8'h10, 32'h3F80_0000);
        rd("we0_n05", 8'h05, 32'h1234_5678);
        rd("we0_n2a", 8'h2A, 32'hDEAD_BEEF);
        bus.rd_en = 1'b0;

        // 6: reset in the middle of a sweep
        bus.WE            = 1'b1;
        bus.select        = 1'b1;
        bus.count_init_en = 1'b1;
        for (int i = 0; i < 97; i++) step();
        check("mid_count", 32'(bus.count_init), 32'd100);
        bus.WE            = 1'b0;
        bus.select        = 1'b0;
        bus.count_init_en = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        check("midrst_count", 32'(bus.count_init), 32'd0);
        check("midrst_done", 32'(bus.init_done), 32'd0);
        step();
        Reset = 1'b0;
        step();
        check("post_count", 32'(bus.count_init), 32'd0);
        rd("post_n50", 8'd50, 32'h3F80_0000);
        rd("post_n2a", 8'h2A, 32'h3F80_0000);
        rd("post_n200", 8'd200, 32'h3F80_0000);
        bus.rd_en = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
